// File: rtl/srff_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// srff_cmd_arbiter
//   Shares one SR flip-flop triple (JK-, D- and T-based implementations with
//   common s/r inputs) between two command requesters. One command is granted
//   at a time with round-robin arbitration. Each command becomes a legal s/r
//   pulse (s and r never both high). A reference register tracks the expected
//   q. All three datapath outputs are cross-checked against it, and every
//   completed command is reported on the rsp_* status port.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset (also resets datapath)
//   req0_valid/req0_cmd  requester 0 command (00 hold, 01 set, 10 reset, 11 toggle)
//   req0_ready           requester 0 accepted when valid & ready
//   req1_valid/req1_cmd  requester 1 command, same encoding
//   req1_ready           requester 1 accepted when valid & ready
//   s, r                 registered set/reset pulse to the SR datapath
//   q_jk, q_d, q_t       datapath outputs under cross-check
//   rsp_valid            one-cycle pulse per completed command
//   rsp_id               requester that issued the completed command
//   rsp_q                expected q after the command
//   rsp_err              any datapath output disagreed with rsp_q
//   err_cnt              saturating count of rsp_err pulses
//   busy                 high whenever the FSM is outside IDLE
// -----------------------------------------------------------------------------
module srff_cmd_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_cmd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_cmd,
  output logic             req1_ready,
  output logic             s,
  output logic             r,
  input  logic             q_jk,
  input  logic             q_d,
  input  logic             q_t,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_q,
  output logic             rsp_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_SET    = 2'b01;
  localparam logic [1:0] CMD_RESET  = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  // Reload value for the settle counter: WAIT lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_M1 = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Map a command and the current expected q onto a legal {s, r} pair.
  // Toggle drives whichever input moves q away from its present value, so
  // s and r can never be requested together.
  function automatic logic [1:0] sr_decode(input logic [1:0] cmd, input logic q);
    logic [1:0] sr;
    case (cmd)
      CMD_HOLD:   sr = 2'b00;
      CMD_SET:    sr = 2'b10;
      CMD_RESET:  sr = 2'b01;
      CMD_TOGGLE: sr = {~q, q};
      default:    sr = 2'b00;
    endcase
    return sr;
  endfunction

  // Expected q once the command has been applied to the datapath.
  function automatic logic next_q(input logic [1:0] cmd, input logic q);
    logic nq;
    case (cmd)
      CMD_HOLD:   nq = q;
      CMD_SET:    nq = 1'b1;
      CMD_RESET:  nq = 1'b0;
      CMD_TOGGLE: nq = ~q;
      default:    nq = q;
    endcase
    return nq;
  endfunction

  state_t           state_r;
  logic [1:0]       cmd_r;
  logic             id_r;
  logic             last_r;
  logic             exp_q_r;
  logic [3:0]       wait_cnt_r;
  logic             s_r;
  logic             r_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic             rsp_q_r;
  logic             rsp_err_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             busy_r;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic [1:0]       grant_cmd_s;
  logic [1:0]       grant_sr_s;
  logic             mismatch_s;

  // Round-robin grant, only evaluated while idle; on a tie the requester
  // that did not win last time is chosen.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~last_r;
      end else if (req0_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end else if (req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign grant_cmd_s = grant_id_s ? req1_cmd : req0_cmd;
  assign grant_sr_s  = sr_decode(grant_cmd_s, exp_q_r);
  assign req0_ready  = grant_valid_s & ~grant_id_s;
  assign req1_ready  = grant_valid_s &  grant_id_s;

  // Any of the three datapath outputs disagreeing with the reference register.
  assign mismatch_s = (q_jk != exp_q_r) | (q_d != exp_q_r) | (q_t != exp_q_r);

  // Command FSM: accept, drive one s/r pulse, settle, check, respond.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cmd_r       <= 2'b00;
      id_r        <= 1'b0;
      last_r      <= 1'b1;
      exp_q_r     <= 1'b0;
      wait_cnt_r  <= 4'd0;
      s_r         <= 1'b0;
      r_r         <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_q_r     <= 1'b0;
      rsp_err_r   <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            // s/r are registered on the accept edge so the pulse is
            // visible during the DRIVE cycle itself.
            cmd_r   <= grant_cmd_s;
            id_r    <= grant_id_s;
            last_r  <= grant_id_s;
            s_r     <= grant_sr_s[1];
            r_r     <= grant_sr_s[0];
            state_r <= ST_DRIVE;
            busy_r  <= 1'b1;
          end else begin
            s_r     <= 1'b0;
            r_r     <= 1'b0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          // The datapath samples s/r on this same edge, so the reference
          // register moves in step with it.
          exp_q_r <= next_q(cmd_r, exp_q_r);
          s_r     <= 1'b0;
          r_r     <= 1'b0;
          if (SETTLE_CYCLES == 0) begin
            state_r <= ST_CHECK;
          end else begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= SETTLE_M1;
          end
        end
        ST_WAIT: begin
          s_r <= 1'b0;
          r_r <= 1'b0;
          if (wait_cnt_r == 4'd0) begin
            state_r <= ST_CHECK;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_CHECK: begin
          s_r         <= 1'b0;
          r_r         <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_id_r    <= id_r;
          rsp_q_r     <= exp_q_r;
          rsp_err_r   <= mismatch_s;
          if (mismatch_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            err_cnt_r <= err_cnt_r;
          end
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          s_r     <= 1'b0;
          r_r     <= 1'b0;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign s         = s_r;
  assign r         = r_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_q     = rsp_q_r;
  assign rsp_err   = rsp_err_r;
  assign err_cnt   = err_cnt_r;
  assign busy      = busy_r;

endmodule

// -----------------------------------------------------------------------------
// srff_cmd_arbiter_chk
//   Property checker for srff_cmd_arbiter: s and r are never high together,
//   and at most one requester sees ready in any cycle.
//
// Ports
//   clk, reset             same clock/reset as the arbiter
//   s, r                   arbiter s/r outputs
//   req0_ready, req1_ready arbiter ready outputs
// -----------------------------------------------------------------------------
module srff_cmd_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic s,
  input logic r,
  input logic req0_ready,
  input logic req1_ready
);

  a_never_s_and_r: assert property (@(posedge clk) disable iff (!reset) !(s && r));
  a_single_ready:  assert property (@(posedge clk) disable iff (!reset) !(req0_ready && req1_ready));

endmodule

// File: tb/tb_srff_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_srff_cmd_arbiter
//   Directed bench for srff_cmd_arbiter. u_dut uses SETTLE_CYCLES=0, CNT_W=2;
//   u_dut3 uses SETTLE_CYCLES=3, CNT_W=8. Each drives a behavioural SR
//   datapath model whose q_t output can be inverted to inject a fault.
// -----------------------------------------------------------------------------
module tb_srff_cmd_arbiter;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] SET    = 2'b01;
  localparam logic [1:0] RESET  = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_cmd = 2'b00, req1_cmd = 2'b00;
  logic       req0_ready, req1_ready, s, r;
  logic       rsp_valid, rsp_id, rsp_q, rsp_err, busy;
  logic [1:0] err_cnt;
  logic       dq = 1'b0;
  logic       fault_t = 1'b0;

  logic       v3_valid = 1'b0;
  logic [1:0] v3_cmd = 2'b00;
  logic       v3_ready, v3_ready1, s3, r3;
  logic       rsp3_valid, rsp3_id, rsp3_q, rsp3_err, busy3;
  logic [7:0] err_cnt3;
  logic       dq3 = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural SR datapath for each DUT (shares the arbiter reset net).
  always @(posedge clk or negedge reset) begin
    if (!reset) dq <= 1'b0;
    else if (s) dq <= 1'b1;
    else if (r) dq <= 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) dq3 <= 1'b0;
    else if (s3) dq3 <= 1'b1;
    else if (r3) dq3 <= 1'b0;
  end

  srff_cmd_arbiter #(.SETTLE_CYCLES(0), .CNT_W(2)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .s(s), .r(r), .q_jk(dq), .q_d(dq), .q_t(dq ^ fault_t),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .err_cnt(err_cnt), .busy(busy)
  );

  srff_cmd_arbiter #(.SETTLE_CYCLES(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(v3_valid), .req0_cmd(v3_cmd), .req0_ready(v3_ready),
    .req1_valid(1'b0), .req1_cmd(2'b00), .req1_ready(v3_ready1),
    .s(s3), .r(r3), .q_jk(dq3), .q_d(dq3), .q_t(dq3),
    .rsp_valid(rsp3_valid), .rsp_id(rsp3_id), .rsp_q(rsp3_q), .rsp_err(rsp3_err),
    .err_cnt(err_cnt3), .busy(busy3)
  );

  srff_cmd_arbiter_chk u_chk (
    .clk(clk), .reset(reset), .s(s), .r(r),
    .req0_ready(req0_ready), .req1_ready(req1_ready)
  );

  srff_cmd_arbiter_chk u_chk3 (
    .clk(clk), .reset(reset), .s(s3), .r(r3),
    .req0_ready(v3_ready), .req1_ready(v3_ready1)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: no s&r overlap and no double ready on either DUT.
  always @(negedge clk) begin
    if (reset) begin
      check_eq("no_overlap", {28'd0, s & r, s3 & r3, req0_ready & req1_ready, v3_ready & v3_ready1}, 32'd0);
    end
  end

  // Present one command, wait (bounded) for its grant, then check the response.
  task automatic do_cmd(input logic id, input logic [1:0] cmd, input logic exp_q,
                        input logic exp_err, input string tag);
    int waited;
    waited = 0;
    if (id) begin req1_valid = 1'b1; req1_cmd = cmd; end
    else    begin req0_valid = 1'b1; req0_cmd = cmd; end
    #1;
    while (((id ? req1_ready : req0_ready) == 1'b0) && (waited < 20)) begin
      tick();
      waited++;
    end
    check_eq({tag, "_grant"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, "_rsp_id"},    {31'd0, rsp_id},    {31'd0, id});
    check_eq({tag, "_rsp_q"},     {31'd0, rsp_q},     {31'd0, exp_q});
    check_eq({tag, "_rsp_err"},   {31'd0, rsp_err},   {31'd0, exp_err});
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset values
    tick();
    check_eq("rst_s",         {31'd0, s},         32'd0);
    check_eq("rst_r",         {31'd0, r},         32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_q",     {31'd0, rsp_q},     32'd0);
    check_eq("rst_err_cnt",   {30'd0, err_cnt},   32'd0);
    check_eq("rst_busy",      {31'd0, busy},      32'd0);
    tick();
    reset = 1'b1;
    #1;

    // Test 1: single set from requester 0
    req0_valid = 1'b1; req0_cmd = SET;
    #1;
    check_eq("t1_ready0", {31'd0, req0_ready}, 32'd1);
    check_eq("t1_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check_eq("t1_s_drive",    {31'd0, s},          32'd1);
    check_eq("t1_r_drive",    {31'd0, r},          32'd0);
    check_eq("t1_busy",       {31'd0, busy},       32'd1);
    check_eq("t1_ready_busy", {31'd0, req0_ready}, 32'd0);
    tick();
    check_eq("t1_s_check",    {31'd0, s},          32'd0);
    check_eq("t1_no_rsp",     {31'd0, rsp_valid},  32'd0);
    tick();
    check_eq("t1_rsp_valid",  {31'd0, rsp_valid},  32'd1);
    check_eq("t1_rsp_id",     {31'd0, rsp_id},     32'd0);
    check_eq("t1_rsp_q",      {31'd0, rsp_q},      32'd1);
    check_eq("t1_rsp_err",    {31'd0, rsp_err},    32'd0);
    check_eq("t1_busy_rsp",   {31'd0, busy},       32'd0);
    tick();
    check_eq("t1_rsp_pulse",  {31'd0, rsp_valid},  32'd0);
    check_eq("t1_rsp_q_hold", {31'd0, rsp_q},      32'd1);

    // Tests 2/3: both requesters toggle continuously from q=0
    reset_pulse();
    req0_valid = 1'b1; req0_cmd = TOGGLE;
    req1_valid = 1'b1; req1_cmd = TOGGLE;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t2_ready0_%0d", k), {31'd0, req0_ready}, {31'd0, (k % 2) == 0});
      check_eq($sformatf("t2_ready1_%0d", k), {31'd0, req1_ready}, {31'd0, (k % 2) == 1});
      tick();
      check_eq($sformatf("t2_s_%0d", k), {31'd0, s}, {31'd0, (k % 2) == 0});
      check_eq($sformatf("t2_r_%0d", k), {31'd0, r}, {31'd0, (k % 2) == 1});
      tick();
      tick();
      check_eq($sformatf("t2_rsp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
      check_eq($sformatf("t2_rsp_id_%0d", k),    {31'd0, rsp_id},    {31'd0, (k % 2) == 1});
      check_eq($sformatf("t2_rsp_q_%0d", k),     {31'd0, rsp_q},     {31'd0, (k % 2) == 0});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check_eq("t2_idle", {31'd0, busy}, 32'd0);

    // Test 4: repeated set, then q_t fault with saturating counter (CNT_W=2)
    do_cmd(1'b0, SET, 1'b1, 1'b0, "t4_set");
    do_cmd(1'b1, SET, 1'b1, 1'b0, "t4_set_again");
    check_eq("t4_cnt0", {30'd0, err_cnt}, 32'd0);
    fault_t = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_cmd(1'b0, HOLD, 1'b1, 1'b1, $sformatf("t4_fault_%0d", i));
      check_eq($sformatf("t4_cnt_%0d", i), {30'd0, err_cnt}, (i < 3) ? (i + 1) : 32'd3);
    end
    fault_t = 1'b0;
    do_cmd(1'b0, RESET, 1'b0, 1'b0, "t4_reset_cmd");
    check_eq("t4_cnt_kept", {30'd0, err_cnt}, 32'd3);

    // Test 6: reset during DRIVE of a set
    req0_valid = 1'b1; req0_cmd = SET;
    #1;
    check_eq("t6_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    check_eq("t6_s_drive", {31'd0, s}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("t6_s",       {31'd0, s},       32'd0);
    check_eq("t6_r",       {31'd0, r},       32'd0);
    check_eq("t6_busy",    {31'd0, busy},    32'd0);
    check_eq("t6_err_cnt", {30'd0, err_cnt}, 32'd0);
    check_eq("t6_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("t6_rsp_q",   {31'd0, rsp_q},   32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t6_no_rsp_%0d", i), {31'd0, rsp_valid}, 32'd0);
    end
    do_cmd(1'b0, HOLD, 1'b0, 1'b0, "t6_hold");

    // Test 5: SETTLE_CYCLES=3 latency and ready gating
    tick();
    v3_valid = 1'b1; v3_cmd = SET;
    #1;
    check_eq("t5_ready_a", {31'd0, v3_ready}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq($sformatf("t5_ready_low_%0d", i), {31'd0, v3_ready},   32'd0);
      check_eq($sformatf("t5_no_rsp_%0d", i),    {31'd0, rsp3_valid}, 32'd0);
      check_eq($sformatf("t5_busy_%0d", i),      {31'd0, busy3},      32'd1);
    end
    tick();
    check_eq("t5_rsp_valid", {31'd0, rsp3_valid}, 32'd1);
    check_eq("t5_rsp_q",     {31'd0, rsp3_q},     32'd1);
    check_eq("t5_rsp_err",   {31'd0, rsp3_err},   32'd0);
    check_eq("t5_ready_a6",  {31'd0, v3_ready},   32'd1);
    v3_valid = 1'b0;
    tick();
    check_eq("t5_rsp_pulse", {31'd0, rsp3_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
